frame_buffer_writer: RTL

Double-buffered pixel frame store sitting directly upstream of the LED matrix scan controller. Accepts a raster-ordered RGB444 pixel stream over a valid/ready handshake, writes it into the back page, and serves the front page to the scan controller as two simultaneous 12-bit words, one for the upper half-panel (bank 1) and one for the lower half-panel (bank 2). Pages swap only at a display frame boundary, so the panel never shows a torn frame.

---
 rtl/frame_buffer_writer_if.sv | 33 +++
 rtl/frame_buffer_writer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/frame_buffer_writer_if.sv
// Bundles the pixel-stream handshake, the scan read port and the page/status flags
// of the double-buffered frame store; the master side is the source/scan side.
interface frame_buffer_writer_if;
  // Pixel handshake: a transfer occurs on every clock edge where i_pix_valid and
  // o_pix_ready are both high; the source holds data/sof stable until then.
  logic        i_pix_valid;
  logic [11:0] i_pix_data;
  logic        i_pix_sof;
  logic        o_pix_ready;

  logic [11:0] i_rd_addr;
  logic        i_rd_stb;
  logic [11:0] o_rd_b1_data;
  logic [11:0] o_rd_b2_data;

  logic        i_frame_sync;
  logic        o_front_page;
  logic        o_frame_done;
  logic        o_resync;
  logic [1:0]  o_state;

  modport master (
    output i_pix_valid, i_pix_data, i_pix_sof, i_rd_addr, i_rd_stb, i_frame_sync,
    input  o_pix_ready, o_rd_b1_data, o_rd_b2_data, o_front_page, o_frame_done,
           o_resync, o_state
  );

  modport slave (
    input  i_pix_valid, i_pix_data, i_pix_sof, i_rd_addr, i_rd_stb, i_frame_sync,
    output o_pix_ready, o_rd_b1_data, o_rd_b2_data, o_front_page, o_frame_done,
           o_resync, o_state
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Double-buffered RGB444 frame store: fills the back page from a raster pixel stream
// and serves both half-panel banks of the front page, swapping only on frame sync.
module frame_buffer_writer #(
  parameter int COLS      = 96,
  parameter int HALF_ROWS = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  frame_buffer_writer_if.slave  bus
);

  localparam int HALF_DEPTH = COLS * HALF_ROWS;
  localparam int COL_W      = $clog2(COLS);
  localparam int ROW_W      = $clog2(2 * HALF_ROWS);
  localparam int ADDR_W     = 12;

  localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]  COL_ONE       = COL_W'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(2 * HALF_ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_HALF_LAST = ROW_W'(HALF_ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_HALF      = ROW_W'(HALF_ROWS);
  localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DEPTH_A       = ADDR_W'(HALF_DEPTH);

  typedef enum logic [1:0] {
    S_SYNC      = 2'd0,
    S_FILL      = 2'd1,
    S_WAIT_SWAP = 2'd2
  } state_t;

  state_t            state_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              front_q, ready_q, done_q, resync_q;
  logic [11:0]       b1_q, b2_q;

  logic [11:0] mem_b1 [0:1][0:HALF_DEPTH-1];
  logic [11:0] mem_b2 [0:1][0:HALF_DEPTH-1];

  logic              xfer, sof, last_pix, wr_en, wr_bank2, back_page;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    xfer      = bus.i_pix_valid & ready_q;
    sof       = bus.i_pix_sof;
    last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    back_page = ~front_q;
    // A sof pixel always restarts at row 0 / col 0, whatever the counters say.
    wr_en     = xfer && ((state_q == S_SYNC && sof) || state_q == S_FILL);
    wr_addr   = sof ? '0 : waddr_q;
    wr_bank2  = ~sof && (row_q >= ROW_HALF);
  end

  always_comb begin
    col_d   = col_q + 1'b1;
    row_d   = row_q;
    waddr_d = waddr_q + 1'b1;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
    if (col_q == COL_LAST && row_q == ROW_HALF_LAST) begin
      waddr_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      if (wr_bank2) mem_b2[back_page][wr_addr] <= bus.i_pix_data;
      else          mem_b1[back_page][wr_addr] <= bus.i_pix_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_SYNC;
      col_q    <= '0;
      row_q    <= '0;
      waddr_q  <= '0;
      front_q  <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      resync_q <= 1'b0;
      b1_q     <= '0;
      b2_q     <= '0;
    end else begin
      done_q   <= 1'b0;
      resync_q <= 1'b0;
      case (state_q)
        S_SYNC: begin
          ready_q <= 1'b1;
          if (xfer && sof) begin
            col_q   <= COL_ONE;
            row_q   <= '0;
            waddr_q <= ADDR_ONE;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (xfer) begin
            if (sof) begin
              col_q    <= COL_ONE;
              row_q    <= '0;
              waddr_q  <= ADDR_ONE;
              resync_q <= 1'b1;
            end else if (last_pix) begin
              ready_q <= 1'b0;
              state_q <= S_WAIT_SWAP;
            end else begin
              col_q   <= col_d;
              row_q   <= row_d;
              waddr_q <= waddr_d;
            end
          end
        end
        S_WAIT_SWAP: begin
          ready_q <= 1'b0;
          if (bus.i_frame_sync) begin
            front_q <= ~front_q;
            done_q  <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            waddr_q <= '0;
            ready_q <= 1'b1;
            state_q <= S_SYNC;
          end
        end
        default: state_q <= S_SYNC;
      endcase

      // Reads use the page selection before any swap on this same edge.
      if (bus.i_rd_stb) begin
        if (bus.i_rd_addr < DEPTH_A) begin
          b1_q <= mem_b1[front_q][bus.i_rd_addr];
          b2_q <= mem_b2[front_q][bus.i_rd_addr];
        end else begin
          b1_q <= '0;
          b2_q <= '0;
        end
      end
    end
  end

  assign bus.o_pix_ready  = ready_q;
  assign bus.o_rd_b1_data = b1_q;
  assign bus.o_rd_b2_data = b2_q;
  assign bus.o_front_page = front_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_resync     = resync_q;
  assign bus.o_state      = state_q;

endmodule
